// File: rtl/event_log_arbiter_if.sv
// Requester-side and log-side signals of event_log_arbiter.
// slave is the arbiter's view, master the environment's view.
interface event_log_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TS_WIDTH   = 32,
  parameter int DEPTH      = 16
);
  localparam int SRC_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [3*NUM_REQ-1:0]          req_level;
  logic [DATA_WIDTH*NUM_REQ-1:0] req_data;
  logic [2:0]                    min_level;
  logic                          resume;
  logic                          log_valid;
  logic                          log_ready;
  logic [TS_WIDTH-1:0]           log_ts;
  logic [SRC_W-1:0]              log_src;
  logic [2:0]                    log_level;
  logic [DATA_WIDTH-1:0]         log_data;
  logic                          frozen;
  logic [CNT_W-1:0]              level_cnt;
  logic [15:0]                   drop_cnt;

  modport slave (
    input  req_valid, req_level, req_data, min_level, resume, log_ready,
    output req_ready, log_valid, log_ts, log_src, log_level, log_data,
           frozen, level_cnt, drop_cnt
  );

  modport master (
    output req_valid, req_level, req_data, min_level, resume, log_ready,
    input  req_ready, log_valid, log_ts, log_src, log_level, log_data,
           frozen, level_cnt, drop_cnt
  );
endinterface

// File: rtl/event_log_arbiter.sv
// Round-robin, level-filtered, timestamped event logger feeding one FWFT FIFO.
// Optional macro EVENT_LOG_ARBITER_DROP_EN: discard (and count) storable events while full.
module event_log_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TS_WIDTH   = 32,
  parameter int DEPTH      = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  event_log_arbiter_if.slave  bus
);
  localparam int SRC_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;
  localparam int REC_W = TS_WIDTH + SRC_W + 3 + DATA_WIDTH;

  typedef enum logic {RUN, FROZEN} state_t;

  state_t                state_reg;
  logic                  frozen_reg;
  logic [TS_WIDTH-1:0]   ts_reg;
  logic [SRC_W-1:0]      rr_reg;
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [REC_W-1:0]      mem [DEPTH];

  logic                  full;
  logic                  empty;
  logic                  run;
  logic                  found;
  logic [SRC_W-1:0]      grant_idx;
  logic [2:0]            grant_level;
  logic [DATA_WIDTH-1:0] grant_data;
  logic                  storable;
  logic                  fatal;
  logic                  accept;
  logic                  push;
  logic                  pop;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign run   = rst_n && (state_reg == RUN);

  // First valid requester at or after the round-robin pointer, with wrap.
  always_comb begin
    int idx;
    idx       = 0;
    found     = 1'b0;
    grant_idx = rr_reg;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_reg) + k) % NUM_REQ;
      if (!found && bus.req_valid[idx]) begin
        found     = 1'b1;
        grant_idx = SRC_W'(idx);
      end
    end
  end

  assign grant_level = bus.req_level[3*grant_idx +: 3];
  assign grant_data  = bus.req_data[DATA_WIDTH*grant_idx +: DATA_WIDTH];
  assign storable    = (grant_level >= bus.min_level);
  assign fatal       = (grant_level >= 3'd5);

`ifdef EVENT_LOG_ARBITER_DROP_EN
  logic        drop;
  logic [15:0] drop_cnt_reg;

  assign accept = run && found;
  assign push   = accept && storable && !full;
  assign drop   = accept && storable && full;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_cnt_reg <= '0;
    end else if (drop && (drop_cnt_reg != 16'hFFFF)) begin
      drop_cnt_reg <= drop_cnt_reg + 16'd1;
    end
  end
  assign bus.drop_cnt = drop_cnt_reg;
`else
  // Filtered events never wait on the FIFO; storable ones back-pressure when full.
  assign accept       = run && found && (!storable || !full);
  assign push         = accept && storable;
  assign bus.drop_cnt = '0;
`endif

  assign pop = !empty && bus.log_ready;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign bus.req_ready[gi] = accept && (grant_idx == SRC_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ts_reg     <= '0;
      rr_reg     <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      state_reg  <= RUN;
      frozen_reg <= 1'b0;
    end else begin
      ts_reg <= ts_reg + 1'b1;
      if (accept) begin
        rr_reg <= (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      // A storable FATAL freezes intake even when resume arrives in the same cycle.
      case (state_reg)
        RUN: begin
          if (accept && storable && fatal) begin
            state_reg  <= FROZEN;
            frozen_reg <= 1'b1;
          end
        end
        FROZEN: begin
          if (bus.resume) begin
            state_reg  <= RUN;
            frozen_reg <= 1'b0;
          end
        end
        default: begin
          state_reg  <= RUN;
          frozen_reg <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg[AW-1:0]] <= {ts_reg, grant_idx, grant_level, grant_data};
    end
  end

  assign {bus.log_ts, bus.log_src, bus.log_level, bus.log_data} = mem[rd_ptr_reg[AW-1:0]];
  assign bus.log_valid = !empty;
  assign bus.frozen    = frozen_reg;
  assign bus.level_cnt = CNT_W'(wr_ptr_reg - rd_ptr_reg);
endmodule

// File: doc/event_log_arbiter.md
Name: event_log_arbiter

Overview:
- Shares one on-chip event-log FIFO among NUM_REQ requesters.
- Each requester presents a severity-tagged event using the TRACE..FATAL level encoding. The block filters events by a minimum level, grants one event per cycle round-robin, stamps it with a free-running timestamp, and buffers it for a single downstream consumer.
- After accepting a FATAL event, the block freezes intake until software resumes it.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_WIDTH, 32, event payload width
TS_WIDTH, 32, timestamp counter width
DEPTH, 16, FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req_valid  in  NUM_REQ  per-requester event valid
req_ready  out  NUM_REQ  per-requester accept (combinational)
req_level  in  3*NUM_REQ  level per requester, slice i = [3i+2:3i]; 0=TRACE 1=DEBUG 2=INFO 3=WARN 4=ERROR 5=FATAL, 6/7 treated as FATAL
req_data  in  DATA_WIDTH*NUM_REQ  payload per requester
min_level  in  3  events with level < min_level are discarded
resume  in  1  single-cycle pulse, leaves FROZEN
log_valid  out  1  output record valid
log_ready  in  1  consumer accept
log_ts  out  TS_WIDTH  timestamp of record
log_src  out  $clog2(NUM_REQ)  granted requester index
log_level  out  3  record level
log_data  out  DATA_WIDTH  record payload
frozen  out  1  high in FROZEN state
level_cnt  out  $clog2(DEPTH+1)  FIFO occupancy
drop_cnt  out  16  dropped-event counter (see Optional Feature)

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - ts=0, FIFO empty, rr pointer=0, state=RUN.
  - log_valid=0, frozen=0, level_cnt=0, drop_cnt=0, all req_ready=0.
  - Reset mid-operation discards FIFO contents and any pending grant.
- Timestamp:
  - ts increments every cycle after reset and wraps modulo 2^TS_WIDTH.
  - A record carries the ts value of its accept cycle.
- Arbitration (RUN only):
  - Candidates are requesters with req_valid=1.
  - Grant the first candidate at or after rr pointer, searching upward with wrap.
  - At most one req_ready bit is high per cycle.
  - On acceptance, rr = granted index+1 mod NUM_REQ. Otherwise rr holds.
- Filtering:
  - If the granted level < min_level, req_ready=1 regardless of FIFO state and the event is discarded.
  - A discarded event does not enter the FIFO, does not trigger FROZEN, and does advance rr.
- Store:
  - If the granted level >= min_level, req_ready=1 only when the FIFO is not full.
  - The event is written at the clk edge.
  - Full + pop in the same cycle: no push; intake waits for the next cycle.
- Output:
  - FIFO is first-word-fall-through from registers; latency from accept to log_valid is 1 cycle when the FIFO is empty.
  - Pop occurs when log_valid & log_ready.
  - log_* hold stable while log_valid=1 and log_ready=0.
  - Simultaneous push and pop (not full) leaves level_cnt unchanged.
- FSM:
  - RUN -> FROZEN on the edge that stores a level>=5 event.
  - FROZEN: all req_ready=0, frozen=1. The FIFO still drains. ts keeps counting.
  - FROZEN -> RUN on the edge where resume=1.
  - resume in RUN is ignored.
  - resume in the same cycle as a FATAL store: the FATAL wins and the state becomes FROZEN.
- Pointers:
  - Write/read pointers are $clog2(DEPTH)+1 bits.
  - Full when the MSBs differ and the rest are equal; empty when all bits are equal.

Optional Feature:
Macro EVENT_LOG_ARBITER_DROP_EN.
- Defined:
  - A storable event granted while the FIFO is full is accepted (req_ready=1) and discarded.
  - drop_cnt increments and saturates at 16'hFFFF.
  - A dropped FATAL still enters FROZEN.
- Undefined:
  - Full FIFO back-pressures as above.
  - drop_cnt is tied to 0.

Test Plan:
- Reset, then req_valid=4'b0000 for 5 cycles -> log_valid=0, level_cnt=0, frozen=0. Reset applied again while FIFO holds 3 entries -> the following cycle level_cnt=0, log_valid=0.
- All 4 requesters valid continuously with level=2 and min_level=0 -> grants in order 0,1,2,3,0; log_src sequence 0,1,2,3; consecutive log_ts differ by 1.
- min_level=3; req0 level=1 data=0xAA, req1 level=4 data=0xBB -> req0 is consumed and discarded; only a record src=1, data=0xBB, level=4 appears.
- log_ready=0 with a single requester valid (level=2) for 20 cycles -> 16 accepts, then req_ready=0 and level_cnt=16. With DROP_EN: 4 more accepts and drop_cnt=4.
- req2 sends level=5 -> frozen=1 the next cycle and req_ready stays 0. The FIFO drains fully with log_ready=1. A resume pulse -> frozen=0 and intake restarts.
- Set TS_WIDTH=4 and run 20 cycles -> log_ts wraps 15->0 with no glitch in the records.
